// File: rtl/seg7_capture_if.sv
// Seven-segment scan lines from the display driver plus the recovered frame and status.
interface seg7_capture_if #(
  parameter int CNT_W = 8
);
  logic [7:0]       AN;
  logic [6:0]       Cnode;
  logic             dp;
  logic [31:0]      bits;
  logic [7:0]       dp_bits;
  logic [7:0]       seen;
  logic             frame_done;
  logic             bad_glyph;
  logic [CNT_W-1:0] err_cnt;

  modport master (
    output AN, Cnode, dp,
    input  bits, dp_bits, seen, frame_done, bad_glyph, err_cnt
  );

  modport slave (
    input  AN, Cnode, dp,
    output bits, dp_bits, seen, frame_done, bad_glyph, err_cnt
  );
endinterface

// File: rtl/seg7_capture.sv
// Recovers 32-bit hex frames from a scanned 8-digit seven-segment display.
// Capture SETTLE_CYCLES+2 cycles after a digit appears, frame load one cycle later; passive monitor, no backpressure.
module seg7_capture #(
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input logic          clk,
  input logic          rst_n,
  seg7_capture_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, HOLD} state_t;

  localparam logic [CNT_W-1:0] STAB_MAX = CNT_W'(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] STAB_THR = CNT_W'(SETTLE_CYCLES - 1);

  state_t           state_q;
  logic [15:0]      in_q;
  logic [15:0]      prev_q;
  logic [CNT_W-1:0] stab_cnt;
  logic [31:0]      shadow_q;
  logic [7:0]       shadow_dp_q;
  logic [7:0]       seen_q;
  logic             frame_pend;
  logic [31:0]      bits_q;
  logic [7:0]       dp_bits_q;
  logic             frame_done_q;
  logic             bad_glyph_q;
  logic [CNT_W-1:0] err_cnt_q;

  logic       changed;
  logic [7:0] an_sel;
  logic       an_valid;
  logic [2:0] dig_idx;
  logic       glyph_ok;
  logic [3:0] glyph_val;
  logic [7:0] seen_upd;

  assign changed  = (in_q != prev_q);
  assign an_sel   = ~in_q[15:8];
  assign an_valid = (an_sel != 8'h00) && ((an_sel & (an_sel - 8'h01)) == 8'h00);

  // Capture reads prev_q: in the SAMPLE cycle it always holds the value that was proven stable.
  always_comb begin
    dig_idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (!prev_q[8+i]) dig_idx = 3'(i);
    end
    glyph_ok  = 1'b1;
    glyph_val = 4'h0;
    case (prev_q[7:1])
      7'h40: glyph_val = 4'h0;
      7'h79: glyph_val = 4'h1;
      7'h24: glyph_val = 4'h2;
      7'h30: glyph_val = 4'h3;
      7'h19: glyph_val = 4'h4;
      7'h12: glyph_val = 4'h5;
      7'h02: glyph_val = 4'h6;
      7'h78: glyph_val = 4'h7;
      7'h00: glyph_val = 4'h8;
      7'h10: glyph_val = 4'h9;
      7'h08: glyph_val = 4'hA;
      7'h03: glyph_val = 4'hB;
      7'h46: glyph_val = 4'hC;
      7'h21: glyph_val = 4'hD;
      7'h06: glyph_val = 4'hE;
      7'h0E: glyph_val = 4'hF;
      default: glyph_ok = 1'b0;
    endcase
    seen_upd = seen_q | (8'h01 << dig_idx);
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q      <= IDLE;
      in_q         <= '0;
      prev_q       <= '0;
      stab_cnt     <= '0;
      shadow_q     <= '0;
      shadow_dp_q  <= '0;
      seen_q       <= '0;
      frame_pend   <= 1'b0;
      bits_q       <= '0;
      dp_bits_q    <= '0;
      frame_done_q <= 1'b0;
      bad_glyph_q  <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      in_q   <= {bus.AN, bus.Cnode, bus.dp};
      prev_q <= in_q;

      if (changed)                stab_cnt <= '0;
      else if (stab_cnt < STAB_MAX) stab_cnt <= stab_cnt + 1'b1;

      frame_done_q <= 1'b0;
      bad_glyph_q  <= 1'b0;

      if (frame_pend) begin
        bits_q       <= shadow_q;
        dp_bits_q    <= shadow_dp_q;
        frame_done_q <= 1'b1;
        seen_q       <= '0;
        frame_pend   <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (an_valid) state_q <= SETTLE;
        end
        SETTLE: begin
          if (!an_valid || changed)     state_q <= IDLE;
          else if (stab_cnt >= STAB_THR) state_q <= SAMPLE;
        end
        SAMPLE: begin
          // A change landing during SAMPLE must not be swallowed by HOLD.
          if (changed) state_q <= an_valid ? SETTLE : IDLE;
          else         state_q <= HOLD;
          if (glyph_ok) begin
            shadow_q[{dig_idx, 2'b00} +: 4] <= glyph_val;
            shadow_dp_q[dig_idx]            <= ~prev_q[0];
            seen_q                          <= seen_upd;
            if (&seen_upd) frame_pend <= 1'b1;
          end else begin
            bad_glyph_q <= 1'b1;
            if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + 1'b1;
          end
        end
        HOLD: begin
          if (changed) state_q <= an_valid ? SETTLE : IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.bits       = bits_q;
  assign bus.dp_bits    = dp_bits_q;
  assign bus.seen       = seen_q;
  assign bus.frame_done = frame_done_q;
  assign bus.bad_glyph  = bad_glyph_q;
  assign bus.err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_seg7_capture.sv
// Directed bench for seg7_capture: scans digits in and checks recovered frames and error status.
module tb_seg7_capture;

  logic clk = 1'b0;
  logic rst_n;
  int   n_assert = 0;
  int   n_fail   = 0;
  int   fd_cnt   = 0;
  int   bad_cnt  = 0;
  int   fd_base;
  int   bad_base;

  seg7_capture_if #(.CNT_W(8)) bus ();

  seg7_capture #(.SETTLE_CYCLES(4), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.frame_done === 1'b1) fd_cnt++;
    if (bus.bad_glyph === 1'b1)  bad_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: glyph = 7'h40;  4'h1: glyph = 7'h79;  4'h2: glyph = 7'h24;  4'h3: glyph = 7'h30;
      4'h4: glyph = 7'h19;  4'h5: glyph = 7'h12;  4'h6: glyph = 7'h02;  4'h7: glyph = 7'h78;
      4'h8: glyph = 7'h00;  4'h9: glyph = 7'h10;  4'hA: glyph = 7'h08;  4'hB: glyph = 7'h03;
      4'hC: glyph = 7'h46;  4'hD: glyph = 7'h21;  4'hE: glyph = 7'h06;  default: glyph = 7'h0E;
    endcase
  endfunction

  task automatic dwell(input logic [7:0] an, input logic [6:0] cn, input logic dpl, input int n);
    bus.AN    = an;
    bus.Cnode = cn;
    bus.dp    = dpl;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_digit(input int i, input logic [3:0] nib, input logic dp_on);
    dwell(~(8'h01 << i), glyph(nib), ~dp_on, 8);
  endtask

  task automatic idle(input int n);
    dwell(8'hFF, 7'h7F, 1'b1, n);
  endtask

  task automatic do_reset();
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  logic [31:0] frame;

  initial begin
    bus.AN = 8'hFF; bus.Cnode = 7'h7F; bus.dp = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);

    // Reset with random scan inputs
    for (int k = 0; k < 2; k++) begin
      bus.AN = 8'($urandom); bus.Cnode = 7'($urandom); bus.dp = 1'($urandom);
      @(negedge clk);
    end
    check("rst_bits", bus.bits, 32'h0);
    check("rst_seen", {24'h0, bus.seen}, 32'h0);
    check("rst_err", {24'h0, bus.err_cnt}, 32'h0);
    check("rst_pulses", {30'h0, bus.frame_done, bus.bad_glyph}, 32'h0);
    idle(1);
    rst_n = 1'b0;
    idle(4);

    // Full frame DEADBEEF, dp on digit 7
    fd_base = fd_cnt; bad_base = bad_cnt;
    frame = 32'hDEADBEEF;
    for (int i = 0; i < 8; i++) send_digit(i, frame[4*i +: 4], i == 7);
    idle(4);
    check("f1_done", fd_cnt - fd_base, 1);
    check("f1_bits", bus.bits, 32'hDEADBEEF);
    check("f1_dp", {24'h0, bus.dp_bits}, 32'h80);
    check("f1_seen", {24'h0, bus.seen}, 32'h0);
    check("f1_bad", bad_cnt - bad_base, 0);

    // Glitch on digit 3: 2-cycle glyph 3 replaced by settled glyph 4
    dwell(8'hF7, 7'h30, 1'b1, 2);
    dwell(8'hF7, 7'h19, 1'b1, 8);
    idle(2);
    check("gl_seen", {24'h0, bus.seen}, 32'h08);
    fd_base = fd_cnt;
    frame = 32'h87654210;
    for (int i = 0; i < 8; i++) if (i != 3) send_digit(i, frame[4*i +: 4], 1'b0);
    idle(4);
    check("gl_done", fd_cnt - fd_base, 1);
    check("gl_bits", bus.bits, 32'h87654210);
    check("gl_dp", {24'h0, bus.dp_bits}, 32'h00);

    // Illegal glyph on digit 0
    bad_base = bad_cnt;
    dwell(8'hFE, 7'h7F, 1'b1, 8);
    idle(2);
    check("ill_pulse", bad_cnt - bad_base, 1);
    check("ill_err1", {24'h0, bus.err_cnt}, 32'h01);
    check("ill_seen", {24'h0, bus.seen}, 32'h00);
    for (int k = 0; k < 255; k++) begin
      dwell(8'hFE, 7'h7F, 1'b1, 8);
      idle(2);
    end
    check("ill_err256", {24'h0, bus.err_cnt}, 32'hFF);
    dwell(8'hFE, 7'h7F, 1'b1, 8);
    idle(2);
    check("ill_sat", {24'h0, bus.err_cnt}, 32'hFF);
    check("ill_pulses", bad_cnt - bad_base, 257);

    // Invalid AN patterns must not capture
    send_digit(5, 4'h3, 1'b0);
    idle(2);
    check("inv_pre", {24'h0, bus.seen}, 32'h20);
    fd_base = fd_cnt; bad_base = bad_cnt;
    dwell(8'hFF, 7'h30, 1'b1, 20);
    dwell(8'hFC, 7'h30, 1'b1, 20);
    idle(2);
    check("inv_seen", {24'h0, bus.seen}, 32'h20);
    check("inv_fd", fd_cnt - fd_base, 0);
    check("inv_bad", bad_cnt - bad_base, 0);

    // Reset mid-frame, then a clean frame of all F
    frame = 32'h01234567;
    for (int i = 0; i < 5; i++) send_digit(i, frame[4*i +: 4], 1'b0);
    idle(2);
    check("mid_seen", {24'h0, bus.seen}, 32'h3F);
    do_reset();
    check("mid_rst_seen", {24'h0, bus.seen}, 32'h0);
    check("mid_rst_bits", bus.bits, 32'h0);
    check("mid_rst_err", {24'h0, bus.err_cnt}, 32'h0);
    rst_n = 1'b0;
    idle(3);
    fd_base = fd_cnt;
    for (int i = 0; i < 8; i++) send_digit(i, 4'hF, 1'b0);
    idle(4);
    check("ff_done", fd_cnt - fd_base, 1);
    check("ff_bits", bus.bits, 32'hFFFFFFFF);
    check("ff_dp", {24'h0, bus.dp_bits}, 32'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
